// File: rtl/palindrome_frame_checker_if.sv
// Word-stream interface for palindrome_frame_checker.
// slave : checker side (takes dataIn/dataVld/dataLast, drives ready and per-frame results).
// master: source/collector side. Optional mismIdx exists only with PALINDROME_MISMATCH_IDX_EN.
interface palindrome_frame_checker_if #(
  parameter int DATA_W    = 8,
  parameter int MAX_DEPTH = 128
);
  localparam int LW = $clog2(MAX_DEPTH + 1);
  localparam int IW = $clog2(MAX_DEPTH);

  logic [DATA_W-1:0] dataIn;
  logic              dataVld;
  logic              dataLast;
  logic              ready;
  logic              isTrue;
  logic              outVld;
  logic [LW-1:0]     outLen;
  logic              dataOvfl;
`ifdef PALINDROME_MISMATCH_IDX_EN
  logic [IW-1:0]     mismIdx;

  modport master (
    output dataIn, dataVld, dataLast,
    input  ready, isTrue, outVld, outLen, dataOvfl, mismIdx
  );
  modport slave (
    input  dataIn, dataVld, dataLast,
    output ready, isTrue, outVld, outLen, dataOvfl, mismIdx
  );
`else
  modport master (
    output dataIn, dataVld, dataLast,
    input  ready, isTrue, outVld, outLen, dataOvfl
  );
  modport slave (
    input  dataIn, dataVld, dataLast,
    output ready, isTrue, outVld, outLen, dataOvfl
  );
`endif
endinterface

// File: rtl/palindrome_frame_checker.sv
// Buffers a dataLast-terminated frame, then checks it from both ends one word pair per cycle.
// Latency: result strobe one cycle after the edge that ends CHECK (C+1 edges after the last beat).
// Backpressure: ready low only while comparing; optional mismIdx via PALINDROME_MISMATCH_IDX_EN.
// Ports: clock, resetN (async active-low), bus (slave modport: stream in, result out).
module palindrome_frame_checker #(
  parameter int DATA_W    = 8,
  parameter int MAX_DEPTH = 128
) (
  input  logic                      clock,
  input  logic                      resetN,
  palindrome_frame_checker_if.slave bus
);
  localparam int LW = $clog2(MAX_DEPTH + 1);
  localparam int IW = $clog2(MAX_DEPTH);
  localparam logic [LW-1:0] LP_MAX  = LW'(MAX_DEPTH);
  localparam logic [IW:0]   LP_SPAN = (IW + 1)'(2);

  typedef enum logic [1:0] {S_LOAD, S_CHECK, S_REPORT} state_t;

  state_t            r_state, w_state;
  logic              r_live;
  logic [LW-1:0]     r_wrPtr, w_wrPtr;
  logic              r_ovfl, w_ovfl;
  logic [IW-1:0]     r_lo, w_lo, r_hi, w_hi;
  logic              r_pendTrue, w_pendTrue, r_pendOvfl, w_pendOvfl;
  logic [LW-1:0]     r_pendLen, w_pendLen;
  logic              r_isTrue, w_isTrue, r_outVld, w_outVld, r_dataOvfl, w_dataOvfl;
  logic [LW-1:0]     r_outLen, w_outLen;
  logic [DATA_W-1:0] r_mem [MAX_DEPTH];
`ifdef PALINDROME_MISMATCH_IDX_EN
  logic [IW-1:0]     r_pendMism, w_pendMism, r_mismIdx, w_mismIdx;
`endif

  logic              w_ready, w_accept, w_full, w_wrEn, w_baseOvfl;
  logic [LW-1:0]     w_basePtr;
  logic [IW:0]       w_span;

  // REPORT behaves like LOAD on an empty buffer, so a beat offered while
  // the result is being registered starts the next frame at word 0.
  always_comb begin
    w_ready    = r_live && (r_state != S_CHECK);
    w_accept   = bus.dataVld && w_ready;
    w_basePtr  = (r_state == S_REPORT) ? '0 : r_wrPtr;
    w_baseOvfl = (r_state == S_REPORT) ? 1'b0 : r_ovfl;
    w_full     = (w_basePtr == LP_MAX);
    w_wrEn     = 1'b0;
    w_span     = {1'b0, r_hi} - {1'b0, r_lo};

    w_state    = r_state;
    w_wrPtr    = r_wrPtr;
    w_ovfl     = r_ovfl;
    w_lo       = r_lo;
    w_hi       = r_hi;
    w_pendTrue = r_pendTrue;
    w_pendOvfl = r_pendOvfl;
    w_pendLen  = r_pendLen;
    w_isTrue   = r_isTrue;
    w_outVld   = 1'b0;
    w_outLen   = r_outLen;
    w_dataOvfl = r_dataOvfl;
`ifdef PALINDROME_MISMATCH_IDX_EN
    w_pendMism = r_pendMism;
    w_mismIdx  = r_mismIdx;
`endif

    case (r_state)
      S_LOAD, S_REPORT: begin
        if (r_state == S_REPORT) begin
          w_state    = S_LOAD;
          w_outVld   = 1'b1;
          w_isTrue   = r_pendTrue;
          w_outLen   = r_pendLen;
          w_dataOvfl = r_pendOvfl;
`ifdef PALINDROME_MISMATCH_IDX_EN
          w_mismIdx  = r_pendMism;
`endif
        end
        w_wrPtr = w_basePtr;
        w_ovfl  = w_baseOvfl;
        if (w_accept) begin
          // Past MAX_DEPTH the beat is consumed but not stored.
          if (w_full) begin
            w_ovfl = 1'b1;
          end else begin
            w_wrEn  = 1'b1;
            w_wrPtr = w_basePtr + LW'(1);
          end
          if (bus.dataLast) begin
            w_wrPtr    = '0;
            w_ovfl     = 1'b0;
            w_pendOvfl = 1'b0;
`ifdef PALINDROME_MISMATCH_IDX_EN
            w_pendMism = '0;
`endif
            if (w_full || w_baseOvfl) begin
              w_state    = S_REPORT;
              w_pendTrue = 1'b0;
              w_pendOvfl = 1'b1;
              w_pendLen  = LP_MAX;
            end else begin
              // Last word sits at basePtr, so hi = len-1 = basePtr.
              w_state   = S_CHECK;
              w_lo      = '0;
              w_hi      = w_basePtr[IW-1:0];
              w_pendLen = w_basePtr + LW'(1);
            end
          end
        end
      end
      S_CHECK: begin
        if (r_mem[r_lo] != r_mem[r_hi]) begin
          w_state    = S_REPORT;
          w_pendTrue = 1'b0;
`ifdef PALINDROME_MISMATCH_IDX_EN
          w_pendMism = r_lo;
`endif
        end else if (w_span <= LP_SPAN) begin
          // Pointers met or straddle the untested middle word.
          w_state    = S_REPORT;
          w_pendTrue = 1'b1;
        end else begin
          w_lo = r_lo + IW'(1);
          w_hi = r_hi - IW'(1);
        end
      end
      default: w_state = S_LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_LOAD;
      r_live     <= 1'b0;
      r_wrPtr    <= '0;
      r_ovfl     <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_pendTrue <= 1'b0;
      r_pendOvfl <= 1'b0;
      r_pendLen  <= '0;
      r_isTrue   <= 1'b0;
      r_outVld   <= 1'b0;
      r_outLen   <= '0;
      r_dataOvfl <= 1'b0;
`ifdef PALINDROME_MISMATCH_IDX_EN
      r_pendMism <= '0;
      r_mismIdx  <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_live     <= 1'b1;
      r_wrPtr    <= w_wrPtr;
      r_ovfl     <= w_ovfl;
      r_lo       <= w_lo;
      r_hi       <= w_hi;
      r_pendTrue <= w_pendTrue;
      r_pendOvfl <= w_pendOvfl;
      r_pendLen  <= w_pendLen;
      r_isTrue   <= w_isTrue;
      r_outVld   <= w_outVld;
      r_outLen   <= w_outLen;
      r_dataOvfl <= w_dataOvfl;
`ifdef PALINDROME_MISMATCH_IDX_EN
      r_pendMism <= w_pendMism;
      r_mismIdx  <= w_mismIdx;
`endif
    end
  end

  // Frame buffer needs no reset: every word is written before it is read.
  always_ff @(posedge clock) begin
    if (w_wrEn) r_mem[w_basePtr[IW-1:0]] <= bus.dataIn;
  end

  assign bus.ready    = w_ready;
  assign bus.isTrue   = r_isTrue;
  assign bus.outVld   = r_outVld;
  assign bus.outLen   = r_outLen;
  assign bus.dataOvfl = r_dataOvfl;
`ifdef PALINDROME_MISMATCH_IDX_EN
  assign bus.mismIdx  = r_mismIdx;
`endif
endmodule

// File: tb/tb_palindrome_frame_checker.sv
// Directed bench for palindrome_frame_checker: frame-level reference model plus literal pins.
module tb_palindrome_frame_checker;
  localparam int DW = 8;
  localparam int MD = 128;
  localparam int BIG = 1 << 30;

  logic clock;
  logic resetN;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  palindrome_frame_checker_if #(.DATA_W(DW), .MAX_DEPTH(MD)) bus_if ();
  palindrome_frame_checker #(.DATA_W(DW), .MAX_DEPTH(MD)) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int   due;
    logic t;
    int   len;
    logic ov;
    int   mism;
  } exp_t;

  exp_t        exq[$];
  exp_t        last_r;
  logic [7:0]  fw[$];
  int          rel_cyc = BIG;
  int          busy_from = 0;
  int          busy_to = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_str(input string s);
    fw.delete();
    for (int i = 0; i < s.len(); i++) fw.push_back(s[i]);
  endtask

  task automatic model_reset();
    exq.delete();
    last_r = '{due: 0, t: 1'b0, len: 0, ov: 1'b0, mism: 0};
    busy_from = 0;
    busy_to = -1;
  endtask

  // Frame result from the rules: reverse-compare words, first bad pair index,
  // compare cycles = index+1 on mismatch, max(1,L/2) on match, 0 on overflow.
  task automatic model_push(input int e);
    exp_t x;
    int   L = fw.size();
    int   c;
    int   bad = -1;
    if (L > MD) begin
      x = '{due: e + 1, t: 1'b0, len: MD, ov: 1'b1, mism: 0};
      c = 0;
    end else begin
      for (int i = 0; i < L / 2; i++)
        if (bad < 0 && fw[i] != fw[L-1-i]) bad = i;
      c = (bad >= 0) ? bad + 1 : ((L / 2 < 1) ? 1 : L / 2);
      x = '{due: e + c + 1, t: (bad < 0), len: L, ov: 1'b0, mism: (bad < 0) ? 0 : bad};
    end
    exq.push_back(x);
    busy_from = e;
    busy_to = e + c - 1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, output int e);
    int budget = 200;
    bus_if.dataIn   = d;
    bus_if.dataVld  = 1'b1;
    bus_if.dataLast = last;
    while (!bus_if.ready && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (!bus_if.ready) begin
      chk("ready_timeout", 0, 1);
      e = cyc;
    end else begin
      @(negedge clock);
      e = cyc;
    end
    bus_if.dataVld  = 1'b0;
    bus_if.dataLast = 1'b0;
  endtask

  task automatic send_frame(input int gap, output int e_last);
    int e = 0;
    for (int i = 0; i < fw.size(); i++) begin
      repeat (gap) @(negedge clock);
      send_beat(fw[i], (i == fw.size() - 1), e);
    end
    e_last = e;
    model_push(e);
  endtask

  task automatic pin(input string name, input int e, input int lat, input int t,
                     input int len, input int ov, input int mism);
    int n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (!bus_if.outVld && n < 400);
    chk({name, "_vld"}, int'(bus_if.outVld), 1);
    chk({name, "_lat"}, cyc - e, lat);
    chk({name, "_true"}, int'(bus_if.isTrue), t);
    chk({name, "_len"}, int'(bus_if.outLen), len);
    chk({name, "_ovfl"}, int'(bus_if.dataOvfl), ov);
`ifdef PALINDROME_MISMATCH_IDX_EN
    chk({name, "_mism"}, int'(bus_if.mismIdx), mism);
`else
    if (mism < 0) chk({name, "_mism"}, mism, 0);
`endif
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    exp_t cur;
    logic exp_rdy;
    forever begin
      @(negedge clock);
      #1;
      if (!resetN) begin
        chk("rst_ready", int'(bus_if.ready), 0);
        chk("rst_outvld", int'(bus_if.outVld), 0);
        chk("rst_istrue", int'(bus_if.isTrue), 0);
        chk("rst_outlen", int'(bus_if.outLen), 0);
        chk("rst_ovfl", int'(bus_if.dataOvfl), 0);
      end else begin
        exp_rdy = (cyc > rel_cyc) && !(cyc >= busy_from && cyc <= busy_to);
        chk("ready", int'(bus_if.ready), int'(exp_rdy));
        while (exq.size() > 0 && exq[0].due < cyc) void'(exq.pop_front());
        if (exq.size() > 0 && exq[0].due == cyc) begin
          cur = exq.pop_front();
          chk("outvld_due", int'(bus_if.outVld), 1);
          last_r = cur;
        end else begin
          chk("outvld_idle", int'(bus_if.outVld), 0);
        end
        chk("istrue", int'(bus_if.isTrue), int'(last_r.t));
        chk("outlen", int'(bus_if.outLen), last_r.len);
        chk("ovfl", int'(bus_if.dataOvfl), int'(last_r.ov));
`ifdef PALINDROME_MISMATCH_IDX_EN
        chk("mismidx", int'(bus_if.mismIdx), last_r.mism);
`endif
      end
    end
  end

  initial begin
    int e;
    int e1;
    model_reset();
    resetN = 1'b1;
    bus_if.dataIn = '0;
    bus_if.dataVld = 1'b0;
    bus_if.dataLast = 1'b0;
    #1 resetN = 1'b0;
    #2;
    chk("init_ready", int'(bus_if.ready), 0);
    chk("init_outvld", int'(bus_if.outVld), 0);
    chk("init_outlen", int'(bus_if.outLen), 0);
    repeat (2) @(negedge clock);
    #3 resetN = 1'b1;
    rel_cyc = cyc;
    #1 chk("rdy_before_edge", int'(bus_if.ready), 0);
    @(negedge clock);
    chk("rdy_after_release", int'(bus_if.ready), 1);

    load_str("abcba");
    send_frame(0, e);
    chk("abcba_rdy_c0", int'(bus_if.ready), 0);
    @(negedge clock);
    chk("abcba_rdy_c1", int'(bus_if.ready), 0);
    @(negedge clock);
    chk("abcba_rdy_c2", int'(bus_if.ready), 1);
    pin("abcba", e, 3, 1, 5, 0, 0);

    load_str("xbcba");
    send_frame(0, e);
    pin("xbcba", e, 2, 0, 5, 0, 0);

    load_str("abcdba");
    send_frame(0, e);
    pin("abcdba", e, 4, 0, 6, 0, 2);

    fw.delete();
    fw.push_back(8'h41);
    send_frame(0, e1);
    load_str("aa");
    send_frame(0, e);
    chk("single_gap", e - e1, 3);
    pin("aa", e, 2, 1, 2, 0, 0);

    load_str("ab");
    send_frame(2, e);
    pin("ab", e, 2, 0, 2, 0, 0);

    load_str("racecar");
    send_frame(1, e);
    pin("racecar", e, 4, 1, 7, 0, 0);

    fw.delete();
    for (int i = 0; i < 130; i++) fw.push_back(8'(i));
    send_frame(0, e);
    pin("ovfl130", e, 1, 0, 128, 1, 0);

    load_str("abba");
    send_frame(0, e);
    pin("abba", e, 3, 1, 4, 0, 0);

    fw.delete();
    for (int i = 0; i < 128; i++) fw.push_back((i < 64) ? 8'(i + 3) : 8'(130 - i));
    send_frame(0, e);
    pin("pal128", e, 65, 1, 128, 0, 0);

    fw[64] = 8'hEE;
    send_frame(0, e);
    pin("mid128", e, 65, 0, 128, 0, 63);

    fw.delete();
    for (int i = 0; i < 64; i++) fw.push_back((i < 32) ? 8'(i) : 8'(63 - i));
    send_frame(0, e);
    repeat (5) @(negedge clock);
    #3 resetN = 1'b0;
    model_reset();
    rel_cyc = BIG;
    #1;
    chk("abort_outvld", int'(bus_if.outVld), 0);
    chk("abort_outlen", int'(bus_if.outLen), 0);
    chk("abort_istrue", int'(bus_if.isTrue), 0);
    chk("abort_ready", int'(bus_if.ready), 0);
    repeat (2) @(negedge clock);
    #3 resetN = 1'b1;
    rel_cyc = cyc;
    #1 chk("rerel_rdy_before", int'(bus_if.ready), 0);
    @(negedge clock);
    chk("rerel_rdy_after", int'(bus_if.ready), 1);

    load_str("aba");
    send_frame(0, e);
    pin("aba", e, 2, 1, 3, 0, 0);

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
